// File: rtl/tm_patch_sequencer.sv
// tm_patch_sequencer: walks every window position of an image in raster order.
// For each position it reads every clause word from port B of the clause BRAM
// and streams {px, py, clause, word} to the clause-evaluation datapath over a
// valid/ready handshake. It reports busy/done/err back to the CSR block.
// Optional build macro PATCH_SEQ_PERF_EN enables the stall_cycles counter.
// Without the macro, stall_cycles is tied to zero.
module tm_patch_sequencer #(
  parameter int BRAM_AW    = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  accel_reset,
  input  logic [9:0]            img_w,
  input  logic [9:0]            img_h,
  input  logic [7:0]            win_w,
  input  logic [7:0]            win_h,
  input  logic [2:0]            stride,
  input  logic [11:0]           num_clauses,
  input  logic [9:0]            patch_max,
  output logic                  c_enb,
  output logic [BRAM_AW-1:0]    c_addrb,
  input  logic [DATA_WIDTH-1:0] c_doutb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9:0]            out_px,
  output logic [9:0]            out_py,
  output logic [11:0]           out_clause,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last_clause,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [9:0]            patch_count,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_CAPT, S_EMIT, S_DONE
  } state_t;

  localparam int unsigned CLAUSE_CAP = 32'd1 << BRAM_AW;

  state_t state, state_nxt;
  logic   start_q;

  // Configuration captured at launch so CSR writes cannot disturb a running pass.
  logic [9:0]  img_w_q, img_h_q, pmax_q;
  logic [7:0]  win_w_q, win_h_q;
  logic [2:0]  stride_q;
  logic [11:0] nc_q;

  logic [9:0]            px, py, pcount;
  logic [11:0]           clause;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic        start_edge, cfg_bad, x_fit, y_fit, final_pos, limit_hit;
  logic        last_clause, pass_end;
  logic [10:0] x_sum, y_sum;

  assign start_edge = start & ~start_q;

  // Window sums are formed at 11 bits so that a 10-bit position cannot wrap.
  assign x_sum     = 11'(px) + 11'(stride_q) + 11'(win_w_q);
  assign y_sum     = 11'(py) + 11'(stride_q) + 11'(win_h_q);
  assign x_fit     = x_sum <= 11'(img_w_q);
  assign y_fit     = y_sum <= 11'(img_h_q);
  assign final_pos = !x_fit && !y_fit;
  assign limit_hit = (pmax_q != 10'd0) && ((11'(pcount) + 11'd1) == 11'(pmax_q));

  assign cfg_bad = (stride_q == 3'd0) || (win_w_q == 8'd0) || (win_h_q == 8'd0) ||
                   (10'(win_w_q) > img_w_q) || (10'(win_h_q) > img_h_q) ||
                   (nc_q == 12'd0);

  assign last_clause = (clause == nc_q - 12'd1);
  assign pass_end    = last_clause && (final_pos || limit_hit);

  // The edge detector follows start every cycle, reset included, so that a level
  // that is already high when reset releases does not look like a fresh edge.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  // State register: async hard reset; the CSR soft reset forces IDLE synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the clock edge.
    if (!rst_n)           state <= S_IDLE;
    else if (accel_reset) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment before the case prevents latch inference.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_edge) state_nxt = S_CHECK;
      S_CHECK: state_nxt = cfg_bad ? S_DONE : S_READ;
      S_READ:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_EMIT;
      S_EMIT:  if (out_ready) state_nxt = pass_end ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and handshake outputs; a soft reset removes valid/busy in the same cycle.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    c_enb     = 1'b0;
    unique case (state)
      S_READ:  begin busy = 1'b1; c_enb = 1'b1; end
      S_CAPT:  busy = 1'b1;
      S_EMIT:  begin busy = 1'b1; out_valid = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (accel_reset) begin
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      c_enb     = 1'b0;
    end
  end

  // Datapath: config latch, raster walk, clause index, word capture and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || accel_reset) begin
      img_w_q <= '0; img_h_q <= '0; win_w_q <= '0; win_h_q <= '0;
      stride_q <= '0; nc_q <= '0; pmax_q <= '0;
      px <= '0; py <= '0; clause <= '0; data_q <= '0;
      pcount <= '0; err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start_edge) begin
          img_w_q  <= img_w;
          img_h_q  <= img_h;
          win_w_q  <= win_w;
          win_h_q  <= win_h;
          stride_q <= stride;
          nc_q     <= (32'(num_clauses) > CLAUSE_CAP) ? 12'(CLAUSE_CAP) : num_clauses;
          pmax_q   <= patch_max;
          pcount   <= '0;
          err_q    <= 1'b0;
        end
        S_CHECK: begin
          if (cfg_bad) err_q <= 1'b1;
          px     <= '0;
          py     <= '0;
          clause <= '0;
        end
        S_CAPT: data_q <= c_doutb;
        S_EMIT: if (out_ready) begin
          if (!last_clause) begin
            clause <= clause + 12'd1;
          end else begin
            clause <= '0;
            if (pcount != 10'h3FF) pcount <= pcount + 10'd1;
            if (!pass_end) begin
              if (x_fit) begin
                px <= px + 10'(stride_q);
              end else begin
                px <= '0;
                py <= py + 10'(stride_q);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PATCH_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Backpressure counter: cycles a beat waits on out_ready, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || accel_reset)                      stall_q <= '0;
    else if (state == S_IDLE && start_edge)         stall_q <= '0;
    else if (state == S_EMIT && !out_ready && stall_q != '1)
                                                    stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign c_addrb         = clause[BRAM_AW-1:0];
  assign out_px          = px;
  assign out_py          = py;
  assign out_clause      = clause;
  assign out_data        = data_q;
  assign out_last_clause = last_clause;
  assign out_last        = last_clause && pass_end;
  assign err             = err_q;
  assign patch_count     = pcount;

endmodule

// File: tb/tb_tm_patch_sequencer.sv
// Directed bench for tm_patch_sequencer: basic pass, odd fit, patch limit,
// configuration errors, backpressure and soft-reset abort.
module tb_tm_patch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, accel_reset, out_ready;
  logic [9:0]  img_w, img_h, patch_max;
  logic [7:0]  win_w, win_h;
  logic [2:0]  stride;
  logic [11:0] num_clauses;
  logic        c_enb, out_valid, out_last_clause, out_last, busy, done, err;
  logic [9:0]  c_addrb, out_px, out_py, patch_count;
  logic [31:0] c_doutb = '0, out_data, stall_cycles;
  logic [11:0] out_clause;

  int tests = 0;
  int fails = 0;

  logic [9:0] xs[4];
  logic [9:0] ys[4];

  tm_patch_sequencer #(.BRAM_AW(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accel_reset(accel_reset),
    .img_w(img_w), .img_h(img_h), .win_w(win_w), .win_h(win_h),
    .stride(stride), .num_clauses(num_clauses), .patch_max(patch_max),
    .c_enb(c_enb), .c_addrb(c_addrb), .c_doutb(c_doutb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_px(out_px), .out_py(out_py), .out_clause(out_clause),
    .out_data(out_data), .out_last_clause(out_last_clause), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .patch_count(patch_count),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {16'hC1A0, 4'h0, a} ^ 32'h0005_A000;
  endfunction

  // Clause BRAM model with one-cycle read latency.
  always @(posedge clk) if (c_enb) c_doutb <= mem_word(12'(c_addrb));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int iw, input int ih, input int ww, input int wh,
                         input int st, input int nc, input int pm);
    img_w = 10'(iw); img_h = 10'(ih); win_w = 8'(ww); win_h = 8'(wh);
    stride = 3'(st); num_clauses = 12'(nc); patch_max = 10'(pm);
  endtask

  task automatic launch();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  // Runs one pass and checks every beat against the position table xs/ys.
  task automatic run_pass(input int npos, input int nc, input int exp_pc,
                          input int stall_beat, input int stall_len, input int abort_beat);
    int   beat, total, dones, left, pos, cl;
    bit   aborted;
    beat = 0; dones = 0; left = stall_len; aborted = 0;
    total = npos * nc;
    launch();
    for (int cyc = 0; cyc < 300 && dones == 0 && !aborted; cyc++) begin
      @(negedge clk);
      if (done) dones++;
      if (out_valid) begin
        pos = beat / nc;
        cl  = beat % nc;
        check($sformatf("beat%0d", beat),
              {out_px, out_py, out_clause, out_data, out_last_clause, out_last},
              {xs[pos], ys[pos], 12'(cl), mem_word(12'(cl)), cl == nc - 1, beat == total - 1});
        if (beat == abort_beat) begin
          accel_reset = 1'b1;
          #1;
          check("abort_valid", out_valid, 1'b0);
          check("abort_busy", busy, 1'b0);
          aborted = 1;
        end else if (beat == stall_beat && left > 0) begin
          out_ready = 1'b0;
          left--;
        end else begin
          out_ready = 1'b1;
          beat++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    if (!aborted) begin
      check("beats", beat, total);
      check("done_pulses", dones, 1);
      check("busy_at_done", busy, 1'b0);
      check("patch_count", patch_count, exp_pc);
      check("err_clear", err, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
    end
  endtask

  task automatic err_case();
    int done_at;
    bit enb_seen, valid_seen;
    done_at = -1; enb_seen = 0; valid_seen = 0;
    launch();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = i;
      enb_seen   |= c_enb;
      valid_seen |= out_valid;
    end
    check("err_done_at", done_at, 2);
    check("err_no_enb", enb_seen, 1'b0);
    check("err_no_beat", valid_seen, 1'b0);
    check("err_flag", err, 1'b1);
    check("err_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; accel_reset = 1'b0; out_ready = 1'b1;
    set_cfg(4, 4, 2, 2, 2, 3, 0);
    xs = '{10'd0, 10'd2, 10'd0, 10'd2};
    ys = '{10'd0, 10'd0, 10'd2, 10'd2};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_status", {busy, done, err, out_valid, c_enb, out_last}, 6'b0);
    check("rst_patch_count", patch_count, 10'd0);
    check("rst_stall", stall_cycles, 32'd0);

    // Basic 4x4 pass, 4 positions x 3 clauses.
    run_pass(4, 3, 4, -1, 0, -1);
    check("basic_stall", stall_cycles, 32'd0);

    // Odd fit: 5x3 image only fits two windows on the top row.
    set_cfg(5, 3, 2, 2, 2, 1, 0);
    run_pass(2, 1, 2, -1, 0, -1);

    // Patch limit: stops after the third window.
    set_cfg(4, 4, 2, 2, 2, 3, 3);
    run_pass(3, 3, 3, -1, 0, -1);

    // Configuration errors.
    set_cfg(4, 4, 2, 2, 0, 3, 0);
    err_case();
    set_cfg(4, 4, 8, 2, 2, 3, 0);
    err_case();

    // Backpressure: beat 2 waits five cycles.
    set_cfg(4, 4, 2, 2, 2, 3, 0);
    run_pass(4, 3, 4, 1, 5, -1);
`ifdef PATCH_SEQ_PERF_EN
    check("stall_cycles", stall_cycles, 32'd5);
`else
    check("stall_cycles", stall_cycles, 32'd0);
`endif

    // Abort on beat 4, then restart from the beginning.
    run_pass(4, 3, 4, 3, 0, 3);
    @(negedge clk);
    accel_reset = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        seen |= done | out_valid | busy;
      end
      check("abort_quiet", seen, 1'b0);
      check("abort_pc_clear", patch_count, 10'd0);
    end
    run_pass(4, 3, 4, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tm_patch_sequencer.md
Name: tm_patch_sequencer

Overview:
- Sequences one convolutional inference pass of the TM accelerator.
- On a CSR start edge, walks every window position of the image in raster order using the programmed geometry and stride.
- For each position, reads every clause word from port B of the clauses BRAM.
- Streams {patch x, patch y, clause index, clause word} to the clause-evaluation datapath over a valid/ready handshake. Reports busy/done/error back to the CSR block.

Parameters:
- BRAM_AW, 10, clause BRAM word-address width.
- DATA_WIDTH, 32, clause word width.

Ports:
- clk  in  1  single clock (also drives c_clkb externally).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  CSR start bit (level); a 0->1 edge launches a pass.
- accel_reset  in  1  CSR soft reset; synchronous, forces IDLE, clears status.
- img_w  in  10  image width in pixels.
- img_h  in  10  image height in pixels.
- win_w  in  8  window width.
- win_h  in  8  window height.
- stride  in  3  window step, x and y.
- num_clauses  in  12  clauses per patch; clamped to 2^BRAM_AW.
- patch_max  in  10  patch limit; 0 = unlimited.
- c_enb  out  1  clause BRAM port-B enable.
- c_addrb  out  BRAM_AW  clause BRAM word address.
- c_doutb  in  DATA_WIDTH  clause BRAM read data, 1-cycle latency.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts beat.
- out_px  out  10  window left x.
- out_py  out  10  window top y.
- out_clause  out  12  clause index.
- out_data  out  DATA_WIDTH  clause word.
- out_last_clause  out  1  last clause of the current patch.
- out_last  out  1  last beat of the pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.
- err  out  1  sticky config error.
- patch_count  out  10  patches fully emitted this pass.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst_n=0 or accel_reset=1): all outputs 0, state IDLE, start-edge register = current start.
- Config inputs are latched at launch; later changes do not affect the running pass.
- IDLE: on start edge, go to CHECK. Edges while busy are ignored.
- CHECK, 1 cycle: error if stride==0, win_w==0, win_h==0, win_w>img_w, win_h>img_h, or num_clauses==0.
  - On error: err=1, done pulse, back to IDLE, no beats emitted.
  - Otherwise: busy=1, px=py=0, clause=0, go to READ.
- READ, 1 cycle: c_enb=1, c_addrb=clause[BRAM_AW-1:0]. Go to CAPT.
- CAPT, 1 cycle: register c_doutb into out_data and set out_valid. Go to EMIT.
- EMIT: hold all out_* stable while out_ready=0. When out_valid&&out_ready:
  - Clause not last: clause++, go to READ.
  - Last clause: patch_count++, clause=0, then advance position:
    - px+=stride if px+stride+win_w<=img_w.
    - Else px=0, py+=stride if py+stride+win_h<=img_h.
    - Else pass complete.
  - Pass also completes when patch_count+1==patch_max (patch_max≠0).
  - On completion go to DONE; otherwise go to READ.
- out_last_clause = (clause==num_clauses-1).
- out_last = out_last_clause AND (final position OR patch limit reached).
- DONE, 1 cycle: done=1, busy=0, go to IDLE. patch_count and err hold until the next launch, which clears them.
- Throughput: 1 beat per 3 cycles with out_ready held high.
- Arithmetic: position sums computed at 11 bits, so no wrap. patch_count saturates at 1023.
- accel_reset mid-pass: immediate abort; out_valid drops the same cycle; no done pulse.

Optional Feature:
- Macro: PATCH_SEQ_PERF_EN.
- Defined: stall_cycles increments each cycle with out_valid=1 and out_ready=0. It saturates at 2^32-1 and clears on launch and on reset.
- Undefined: stall_cycles tied to 0, no counter logic.

Test Plan:
- Basic pass: img 4x4, win 2x2, stride 2, num_clauses 3, patch_max 0, ready high.
  - Expect 12 beats, positions (0,0),(2,0),(0,2),(2,2), clause 0..2 each.
  - out_data equals BRAM contents; out_last on beat 12 only; done pulse; patch_count=4.
- Odd fit: img 5x3, win 2x2, stride 2, num_clauses 1.
  - Positions (0,0),(2,0) only; patch_count=2.
- Patch limit: the basic-pass config with patch_max=3.
  - 9 beats; out_last on (0,2) clause 2; patch_count=3.
- Config error: stride=0, or win_w=8 with img_w=4.
  - err=1 and done pulse within 2 cycles of the start edge; zero beats; c_enb never asserted.
- Backpressure: basic-pass config, out_ready low 5 cycles on beat 2.
  - Beat held stable; sequence otherwise identical.
  - With PATCH_SEQ_PERF_EN defined, stall_cycles=5.
- Abort: accel_reset pulsed on beat 4, then a new start edge.
  - out_valid and busy drop immediately; no done pulse.
  - Restarted pass begins at (0,0) clause 0.
